pn_fire_scheduler: RTL and testbench
====================================

Name: pn_fire_scheduler

Overview:
- Sequences the Petri-net marking datapath: evaluates per-transition fire counts, arbitrates one winning transition per step, and hands it to the marking-update block over a valid/ready handshake.
- Supports free-run, single-step and halt control, fixed-priority or round-robin arbitration, and deadlock detection.
- Sits between the transition-enable logic (which produces f0..fN) and the place-register update block.

Parameters:
- NT, 3, number of transitions (2..16).
- CW, 32, width of each fire count and marking value.
- POLICY, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- DEAD_LIMIT, 4, consecutive empty evaluations before deadlock is declared (1..255).
- SCW, 16, width of the fired-step counter.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = free-run stepping
- step  in  1  one-cycle pulse; performs one evaluation/fire while not running
- clear  in  1  one-cycle pulse; exits DEAD and zeroes counters
- t_cnt  in  NT*CW  packed fire counts; slice i = transition i; enabled iff slice != 0
- fire_valid  out  1  firing request to marking datapath
- fire_ready  in  1  marking datapath accepts the firing
- fire_idx  out  IW = max(1,$clog2(NT))  winning transition index
- fire_cnt  out  CW  token multiplicity for the firing
- busy  out  1  high in any state except IDLE and DEAD
- dead  out  1  deadlock flag
- fire_total  out  SCW  number of accepted firings, wraps modulo 2^SCW

Behaviour:
- Reset (async, sys_rst_n=0) sets all outputs and state to 0: state=IDLE, fire_valid=0, fire_idx=0, fire_cnt=0, dead=0, fire_total=0, rr_ptr=0, idle_cnt=0, single=0.
- States: IDLE, EVAL, FIRE, SETTLE, DEAD.
- IDLE:
  - run=1 → EVAL with single=0.
  - Otherwise step=1 → EVAL with single=1.
  - A step pulse while run=1 is ignored.
- EVAL (1 cycle): computes en[i] = (t_cnt slice i != 0).
  - Winner selection:
    - POLICY 0: lowest set index.
    - POLICY 1: first set index at or after rr_ptr, wrapping modulo NT.
  - Any en set: latch fire_idx and fire_cnt from the winner's slice, clear idle_cnt, go to FIRE. fire_valid rises on the next cycle.
  - No en set: idle_cnt++.
    - If idle_cnt reaches DEAD_LIMIT → DEAD, dead=1.
    - Otherwise → SETTLE.
- FIRE:
  - fire_valid=1; fire_idx and fire_cnt stay stable until the handshake completes.
  - On fire_valid & fire_ready: fire_total++, rr_ptr = (fire_idx+1) mod NT, fire_valid drops on the next cycle, go to SETTLE.
  - run falling during FIRE does not abort; the handshake always completes.
- SETTLE (1 cycle): lets marking registers and enable logic propagate.
  - single=1 or run=0 → IDLE, single cleared.
  - Otherwise → EVAL.
- Step latency: EVAL to fire_valid = 1 cycle. Minimum firing period = 3 cycles with fire_ready tied high (EVAL, FIRE, SETTLE).
- DEAD: fire_valid=0, dead=1, busy=0. Only clear (or reset) exits: dead=0, idle_cnt=0, fire_total=0 → IDLE.
- clear outside DEAD: zeroes fire_total and idle_cnt only; state is unaffected.
- Simultaneous clear and handshake: clear wins (fire_total=0).
- An empty evaluation in single-step mode still counts toward idle_cnt and returns to IDLE through SETTLE.
- t_cnt is sampled only in EVAL; changes at any other time are ignored.
- Enabled-ness is computed from the full CW bits; no truncation.
- rr_ptr is unused when POLICY=0 but still held at 0.

Decomposition:
- Shared package pn_pkg holds:
  - the state enum (IDLE/EVAL/FIRE/SETTLE/DEAD);
  - the POLICY_FIXED / POLICY_RR constants;
  - a function idx_width(NT).
- Sub-module pn_rr_arbiter (NT-wide request vector, ptr, policy → grant index plus any-grant): purely combinational and reused by future multi-net controllers.
- The scheduler FSM, counters and output registers live in pn_fire_scheduler.

Test Plan:
- Priority: POLICY=0, t_cnt={f2=1,f1=5,f0=12}, run=1, fire_ready=1 → first firing idx=0 cnt=12, fire_valid asserted exactly 1 cycle after EVAL.
- Round-robin: POLICY=1, all three slices held at 1 → fire_idx sequence 0,1,2,0 across four firings, fire_total=4.
- Backpressure/halt: fire_ready=0 for 5 cycles, run dropped during FIRE → fire_idx/fire_cnt stable while waiting; fire_ready=1 → one accept, fire_total+1, then IDLE with busy=0.
- Single step: run=0, one step pulse with f1=3 enabled → exactly one firing idx=1 cnt=3, back in IDLE 3 cycles later; a second step with t_cnt=0 → no fire_valid, idle_cnt=1.
- Deadlock: DEAD_LIMIT=4, run=1, t_cnt=0 → dead=1 after the 4th EVAL; step ignored; clear → dead=0, fire_total=0, IDLE.
- Async reset mid-FIRE: sys_rst_n low while fire_valid=1 → fire_valid=0 and all outputs 0 immediately, without waiting for a clock edge; after release the block resumes from IDLE.

Source files
------------

// File: rtl/pn_pkg.sv
// ============================================================================
// Module   : pn_pkg
// Purpose  : Shared definitions for the Petri-net firing scheduler family:
//            scheduler state encoding, arbitration policy codes and the
//            transition-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pn_pkg;

  // Scheduler states, explicitly encoded so that waveforms stay readable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  localparam int POLICY_FIXED = 0;  // lowest enabled index wins
  localparam int POLICY_RR    = 1;  // first enabled index at/after rr pointer

  // Width of a transition index; never below one bit so NT=2 still works.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : pn_pkg

`default_nettype wire

// File: rtl/pn_rr_arbiter.sv
// ============================================================================
// Module   : pn_rr_arbiter
// Purpose  : Combinational one-of-NT arbiter. With policy_rr=0 the lowest
//            set request wins; with policy_rr=1 the search starts at ptr and
//            wraps modulo NT.
// Ports    : req       [NT-1:0] request vector
//            ptr       [IW-1:0] round-robin start index (must be < NT)
//            policy_rr          1 = rotate from ptr, 0 = fixed priority
//            grant     [IW-1:0] winning index (0 when no request)
//            any                at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pn_rr_arbiter
  import pn_pkg::*;
#(
  parameter int NT = 3,
  parameter int IW = idx_width(NT)
) (
  input  logic [NT-1:0] req,
  input  logic [IW-1:0] ptr,
  input  logic          policy_rr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] w_start;
  logic          w_found;

  // (p + k) mod NT, valid for p < NT and k < NT.
  function automatic int wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NT) s = s - NT;
    return s;
  endfunction

  // Fixed priority is simply a rotating search anchored at index 0.
  assign w_start = policy_rr ? ptr : '0;
  assign any     = |req;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NT; k++) begin
      if (!w_found && req[wrap_idx(w_start, k)]) begin
        grant   = IW'(wrap_idx(w_start, k));
        w_found = 1'b1;
      end
    end
  end

endmodule : pn_rr_arbiter

`default_nettype wire

// File: rtl/pn_fire_scheduler.sv
// ============================================================================
// Module   : pn_fire_scheduler
// Purpose  : Steps a Petri-net marking datapath. Each step evaluates the
//            per-transition fire counts, picks one winner and offers it to
//            the marking-update block over a valid/ready handshake.
//            Supports free-run, single-step, halt and deadlock detection.
// Ports    : sys_clk, sys_rst_n   clock, asynchronous active-low reset
//            run                  level, free-run stepping
//            step                 pulse, one evaluation while not running
//            clear                pulse, leaves DEAD and zeroes counters
//            t_cnt   [NT*CW-1:0]  packed fire counts, slice i = transition i
//            fire_valid/ready     firing handshake
//            fire_idx [IW-1:0]    winning transition
//            fire_cnt [CW-1:0]    token multiplicity of the firing
//            busy                 not IDLE and not DEAD
//            dead                 deadlock flag
//            fire_total [SCW-1:0] accepted firings, wraps
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pn_fire_scheduler
  import pn_pkg::*;
#(
  parameter int NT         = 3,
  parameter int CW         = 32,
  parameter int POLICY     = 0,
  parameter int DEAD_LIMIT = 4,
  parameter int SCW        = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     run,
  input  logic                     step,
  input  logic                     clear,
  input  logic [NT*CW-1:0]         t_cnt,
  output logic                     fire_valid,
  input  logic                     fire_ready,
  output logic [idx_width(NT)-1:0] fire_idx,
  output logic [CW-1:0]            fire_cnt,
  output logic                     busy,
  output logic                     dead,
  output logic [SCW-1:0]           fire_total
);

  localparam int            IW          = idx_width(NT);
  localparam logic [IW-1:0] C_LAST_IDX  = IW'(NT - 1);
  localparam logic          C_POLICY_RR = (POLICY == POLICY_RR);

  state_t        r_state, w_state_nxt;
  logic          r_single, w_single_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [7:0]    r_idle_cnt;

  logic [NT-1:0] w_en;
  logic [IW-1:0] w_win;
  logic          w_any;
  logic [CW-1:0] w_win_cnt;
  logic [8:0]    w_idle_inc;
  logic          w_dead_hit;
  logic          w_latch, w_accept, w_empty_eval;

  // Enabled-ness looks at every bit of the slice, never a truncated view.
  for (genvar gi = 0; gi < NT; gi++) begin : g_en
    assign w_en[gi] = |t_cnt[gi*CW +: CW];
  end

  pn_rr_arbiter #(
    .NT (NT),
    .IW (IW)
  ) u_arb (
    .req       (w_en),
    .ptr       (r_rr_ptr),
    .policy_rr (C_POLICY_RR),
    .grant     (w_win),
    .any       (w_any)
  );

  always_comb begin
    w_win_cnt = '0;
    for (int i = 0; i < NT; i++) begin
      if (w_win == IW'(i)) w_win_cnt = t_cnt[i*CW +: CW];
    end
  end

  // Look-ahead of the idle counter after this empty evaluation.
  assign w_idle_inc = {1'b0, r_idle_cnt} + 9'd1;
  assign w_dead_hit = (w_idle_inc >= 9'(DEAD_LIMIT));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_single <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_single <= w_single_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_single_nxt = r_single;
    w_latch      = 1'b0;
    w_accept     = 1'b0;
    w_empty_eval = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt  = ST_EVAL;
          w_single_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt  = ST_EVAL;
          w_single_nxt = 1'b1;
        end
      end
      ST_EVAL: begin
        if (w_any) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_FIRE;
        end else begin
          w_empty_eval = 1'b1;
          w_state_nxt  = w_dead_hit ? ST_DEAD : ST_SETTLE;
        end
      end
      ST_FIRE: begin
        // run is deliberately ignored here: an offered firing always completes.
        if (fire_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_single || !run) begin
          w_state_nxt  = ST_IDLE;
          w_single_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_EVAL;
        end
      end
      ST_DEAD: begin
        if (clear) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fire_idx   <= '0;
      fire_cnt   <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
      fire_total <= '0;
    end else begin
      if (w_latch) begin
        fire_idx <= w_win;
        fire_cnt <= w_win_cnt;
      end

      if (w_accept && C_POLICY_RR) begin
        r_rr_ptr <= (fire_idx == C_LAST_IDX) ? '0 : fire_idx + 1'b1;
      end

      // clear has priority over a same-cycle handshake or evaluation.
      if (clear) begin
        fire_total <= '0;
      end else if (w_accept) begin
        fire_total <= fire_total + 1'b1;
      end

      if (clear || w_latch) begin
        r_idle_cnt <= '0;
      end else if (w_empty_eval) begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end
    end
  end

  // Status outputs decode straight from the state register so the async
  // reset clears them without waiting for a clock edge.
  assign fire_valid = (r_state == ST_FIRE);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DEAD);
  assign dead       = (r_state == ST_DEAD);

endmodule : pn_fire_scheduler

`default_nettype wire

// File: tb/tb_pn_fire_scheduler.sv
// ============================================================================
// Module   : tb_pn_fire_scheduler
// Purpose  : Self-checking bench for pn_fire_scheduler. Two instances share
//            stimulus: u_fp (fixed priority) and u_rr (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pn_fire_scheduler;

  localparam int NT = 3;
  localparam int CW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          clear = 1'b0;
  logic          fire_ready = 1'b1;
  logic [NT*CW-1:0] t_cnt = '0;

  logic          fp_valid, fp_busy, fp_dead;
  logic [1:0]    fp_idx;
  logic [CW-1:0] fp_cnt;
  logic [15:0]   fp_total;
  logic          rr_valid, rr_busy, rr_dead;
  logic [1:0]    rr_idx;
  logic [CW-1:0] rr_cnt;
  logic [15:0]   rr_total;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  pn_fire_scheduler #(
    .NT(NT), .CW(CW), .POLICY(0), .DEAD_LIMIT(4), .SCW(16)
  ) u_fp (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run(run), .step(step),
    .clear(clear), .t_cnt(t_cnt), .fire_valid(fp_valid),
    .fire_ready(fire_ready), .fire_idx(fp_idx), .fire_cnt(fp_cnt),
    .busy(fp_busy), .dead(fp_dead), .fire_total(fp_total)
  );

  pn_fire_scheduler #(
    .NT(NT), .CW(CW), .POLICY(1), .DEAD_LIMIT(4), .SCW(16)
  ) u_rr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run(run), .step(step),
    .clear(clear), .t_cnt(t_cnt), .fire_valid(rr_valid),
    .fire_ready(fire_ready), .fire_idx(rr_idx), .fire_cnt(rr_cnt),
    .busy(rr_busy), .dead(rr_dead), .fire_total(rr_total)
  );

  typedef struct packed {
    logic [NT*CW-1:0] t;
    logic             fire;
    logic [1:0]       idx;
    logic [CW-1:0]    cnt;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [NT*CW-1:0] t, input logic fire,
                              input logic [1:0] idx, input logic [CW-1:0] cnt);
    vec_t v;
    v.t = t; v.fire = fire; v.idx = idx; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    run = 1'b0; step = 1'b0; clear = 1'b0; fire_ready = 1'b1;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_model;
    int nfire;
    int w;
    int n;
    logic [1:0] exp_rr [4];

    // Single-step vectors, t = {f2, f1, f0}.
    vecs[0] = mk({32'd1, 32'd5, 32'd12}, 1'b1, 2'd0, 32'd12);
    vecs[1] = mk({32'd0, 32'd3, 32'd0},  1'b1, 2'd1, 32'd3);
    vecs[2] = mk({32'd7, 32'd0, 32'd0},  1'b1, 2'd2, 32'd7);
    vecs[3] = mk({32'd0, 32'd0, 32'd0},  1'b0, 2'd0, 32'd0);
    vecs[4] = mk({32'd0, 32'h8000_0000, 32'd0}, 1'b1, 2'd1, 32'h8000_0000);
    vecs[5] = mk({32'hFFFF_FFFF, 32'd0, 32'd0}, 1'b1, 2'd2, 32'hFFFF_FFFF);
    vecs[6] = mk({32'd0, 32'd0, 32'd0},  1'b0, 2'd0, 32'd0);
    vecs[7] = mk({32'd9, 32'd9, 32'd0},  1'b1, 2'd1, 32'd9);

    // ---------------- reset state ----------------
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(fp_valid), 32'd0);
    chk("rst_idx",   32'(fp_idx),   32'd0);
    chk("rst_cnt",   fp_cnt,        32'd0);
    chk("rst_busy",  32'(fp_busy),  32'd0);
    chk("rst_dead",  32'(fp_dead),  32'd0);
    chk("rst_total", 32'(fp_total), 32'd0);
    chk("rst_rr_valid", 32'(rr_valid), 32'd0);
    reset_dut();

    // ---------------- table-driven single steps ----------------
    idle_model = 0;
    nfire = 0;
    for (int i = 0; i < 8; i++) begin
      t_cnt = vecs[i].t;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(fp_valid), 32'(vecs[i].fire));
      if (vecs[i].fire) begin
        chk($sformatf("vec%0d_idx", i), 32'(fp_idx), 32'(vecs[i].idx));
        chk($sformatf("vec%0d_cnt", i), fp_cnt, vecs[i].cnt);
        tick();
        nfire++;
        idle_model = 0;
      end else begin
        idle_model++;
      end
      tick();
      chk($sformatf("vec%0d_idle_busy", i), 32'(fp_busy), 32'd0);
      chk($sformatf("vec%0d_idle_cnt", i), 32'(u_fp.r_idle_cnt), 32'(idle_model));
    end
    chk("table_total", 32'(fp_total), 32'(nfire));

    // clear outside DEAD zeroes the counter and leaves the state alone
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_idle_total", 32'(fp_total), 32'd0);
    chk("clear_idle_busy",  32'(fp_busy),  32'd0);

    // ---------------- free-run priority, first-firing latency ----------------
    reset_dut();
    t_cnt = {32'd1, 32'd5, 32'd12};
    run = 1'b1;
    tick();
    chk("prio_eval_valid", 32'(fp_valid), 32'd0);
    chk("prio_eval_busy",  32'(fp_busy),  32'd1);
    tick();
    chk("prio_fire_valid", 32'(fp_valid), 32'd1);
    chk("prio_fire_idx",   32'(fp_idx),   32'd0);
    chk("prio_fire_cnt",   fp_cnt,        32'd12);
    run = 1'b0;
    tick();
    chk("prio_settle_valid", 32'(fp_valid), 32'd0);
    chk("prio_total", 32'(fp_total), 32'd1);
    tick();
    chk("prio_idle_busy", 32'(fp_busy), 32'd0);

    // ---------------- round-robin sequence ----------------
    reset_dut();
    exp_rr[0] = 2'd0; exp_rr[1] = 2'd1; exp_rr[2] = 2'd2; exp_rr[3] = 2'd0;
    t_cnt = {32'd1, 32'd1, 32'd1};
    run = 1'b1;
    for (int f = 0; f < 4; f++) begin
      w = 0;
      while (!rr_valid && w < 10) begin
        tick();
        w++;
      end
      if (!rr_valid) chk($sformatf("rr%0d_timeout", f), 32'd0, 32'd1);
      else chk($sformatf("rr%0d_idx", f), 32'(rr_idx), 32'(exp_rr[f]));
      if (f == 3) run = 1'b0;
      tick();
    end
    tick();
    chk("rr_total", 32'(rr_total), 32'd4);
    chk("rr_idle_busy", 32'(rr_busy), 32'd0);

    // ---------------- backpressure with run dropped ----------------
    reset_dut();
    fire_ready = 1'b0;
    t_cnt = {32'd0, 32'd4, 32'd0};
    run = 1'b1;
    tick();
    tick();
    chk("bp_valid", 32'(fp_valid), 32'd1);
    run = 1'b0;
    t_cnt = {32'd0, 32'd0, 32'd99};
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c),
          32'(fp_valid && fp_idx == 2'd1 && fp_cnt == 32'd4), 32'd1);
    end
    chk("bp_total_wait", 32'(fp_total), 32'd0);
    fire_ready = 1'b1;
    tick();
    chk("bp_after_valid", 32'(fp_valid), 32'd0);
    chk("bp_after_total", 32'(fp_total), 32'd1);
    tick();
    chk("bp_idle_busy", 32'(fp_busy), 32'd0);

    // ---------------- deadlock ----------------
    reset_dut();
    t_cnt = {32'd0, 32'd0, 32'd2};
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
    chk("dl_pre_total", 32'(fp_total), 32'd1);
    t_cnt = '0;
    run = 1'b1;
    n = 0;
    while (!fp_dead && n < 30) begin
      tick();
      n++;
    end
    chk("dl_edges_to_dead", 32'(n), 32'd8);
    chk("dl_busy", 32'(fp_busy), 32'd0);
    chk("dl_valid", 32'(fp_valid), 32'd0);
    chk("dl_total_kept", 32'(fp_total), 32'd1);
    run = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("dl_step_ignored", 32'(fp_dead), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("dl_clear_dead",  32'(fp_dead),  32'd0);
    chk("dl_clear_total", 32'(fp_total), 32'd0);
    chk("dl_clear_busy",  32'(fp_busy),  32'd0);
    tick();
    chk("dl_stays_idle",  32'(fp_busy),  32'd0);

    // ---------------- asynchronous reset during FIRE ----------------
    reset_dut();
    fire_ready = 1'b0;
    t_cnt = {32'd0, 32'd6, 32'd0};
    run = 1'b1;
    tick();
    tick();
    chk("ar_valid_before", 32'(fp_valid), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(fp_valid), 32'd0);
    chk("ar_idx",   32'(fp_idx),   32'd0);
    chk("ar_cnt",   fp_cnt,        32'd0);
    chk("ar_busy",  32'(fp_busy),  32'd0);
    #2;
    sys_rst_n = 1'b1;
    fire_ready = 1'b1;
    tick();
    tick();
    chk("ar_resume_valid", 32'(fp_valid), 32'd1);
    chk("ar_resume_idx",   32'(fp_idx),   32'd1);
    chk("ar_resume_cnt",   fp_cnt,        32'd6);
    run = 1'b0;
    tick();
    tick();
    chk("ar_resume_idle", 32'(fp_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pn_fire_scheduler

`default_nettype wire
